// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the fetch buffer entry type.
`default_nettype none

package rv32_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// Two-entry instruction/PC buffer between instruction memory and decode.
`default_nettype none

module fetch_fifo
  import rv32_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    if (flush_i) begin
      count_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= push_entry_i;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (do_pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// Instruction fetch: PC sequencing, redirect handling and a 2-deep response buffer.
`default_nettype none

module fetch_ctrl
  import rv32_pkg::*;
#(
  parameter int              INST_MEMORY_SIZE = 1024,
  parameter int              ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
  parameter logic [XLEN-1:0] RESET_PC         = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [ILEN-1:0]       imem_data,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ILEN-1:0]       out_instr,
  output logic [XLEN-1:0]       out_pc
);

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q;
  logic [XLEN-1:0] inflight_pc_d;
  logic            inflight_q;
  logic            inflight_d;

  logic [1:0]      fifo_count;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  fetch_entry_t    fifo_head;
  fetch_entry_t    resp_entry;
  fetch_entry_t    out_entry;

  logic            pop;
  logic            issue;
  logic [2:0]      occupancy;
  logic [XLEN-1:0] redirect_target;

  assign imem_addr       = fetch_pc_q[ADDR_WIDTH+1:2];
  assign redirect_target = redirect_pc & ~32'h0000_0003;

  // The memory response bypasses the empty buffer so decode sees it the
  // cycle it arrives; otherwise the buffer head is presented.
  assign fifo_empty = (fifo_count == 2'd0);
  assign resp_entry = {imem_data, inflight_pc_q};
  assign out_entry  = fifo_empty ? resp_entry : fifo_head;
  assign out_valid  = !fifo_empty || inflight_q;
  assign out_instr  = out_valid ? out_entry.instr : '0;
  assign out_pc     = out_valid ? out_entry.pc : '0;
  assign pop        = out_valid && out_ready;

  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = !redirect_valid && (occupancy < 3'd2);

  // A bypassed response consumed directly by decode never enters the buffer.
  assign fifo_push = inflight_q && !redirect_valid && !(pop && fifo_empty);
  assign fifo_pop  = pop && !fifo_empty && !redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_fifo u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (fifo_push),
    .push_entry_i (resp_entry),
    .pop_i        (fifo_pop),
    .flush_i      (redirect_valid),
    .count_o      (fifo_count),
    .head_o       (fifo_head)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a word-indexed instruction memory model.
`default_nettype none

module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_cmp;
  int n_err;
  logic [31:0] exp_pc;

  fetch_ctrl #(
    .INST_MEMORY_SIZE (1024)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory preloaded with word i = 0x1000_0000 + i, one-cycle read latency.
  always @(posedge clk) imem_data <= 32'h1000_0000 + 32'(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_instr", out_instr, 32'h0);
    check_eq("rst_pc", out_pc, 32'h0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);

    rst_n = 1'b1;
    #1;
    check_eq("rel_valid", 32'(out_valid), 32'd0);
    check_eq("rel_addr", 32'(imem_addr), 32'd0);

    // Streaming from reset
    exp_pc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("stream_valid", 32'(out_valid), 32'd1);
      check_eq("stream_pc", out_pc, exp_pc);
      check_eq("stream_instr", out_instr, 32'h1000_0000 + (exp_pc >> 2));
      exp_pc = exp_pc + 32'd4;
    end

    // Backpressure: head must stay put, buffer fills to two
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_pc", out_pc, exp_pc);
      check_eq("hold_instr", out_instr, 32'h1000_0000 + (exp_pc >> 2));
      if (s >= 2) check_eq("hold_count", 32'(u_dut.u_fifo.count_o), 32'd2);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      check_eq("resume_valid", 32'(out_valid), 32'd1);
      check_eq("resume_pc", out_pc, exp_pc);
      check_eq("resume_instr", out_instr, 32'h1000_0000 + (exp_pc >> 2));
      exp_pc = exp_pc + 32'd4;
    end

    // Single-cycle redirect to a misaligned target
    @(negedge clk);
    check_eq("pre_redir_pc", out_pc, exp_pc);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_eq("redir_gap_valid", 32'(out_valid), 32'd0);
    check_eq("redir_addr", 32'(imem_addr), 32'h40);
    @(negedge clk);
    check_eq("redir_valid", 32'(out_valid), 32'd1);
    check_eq("redir_pc", out_pc, 32'h100);
    check_eq("redir_instr", out_instr, 32'h1000_0040);
    @(negedge clk);
    check_eq("redir_next_pc", out_pc, 32'h104);
    check_eq("redir_next_instr", out_instr, 32'h1000_0041);

    // Word-address wrap at the top of memory
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0FFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_eq("wrap_gap_valid", 32'(out_valid), 32'd0);
    check_eq("wrap_addr_top", 32'(imem_addr), 32'd1023);
    @(negedge clk);
    check_eq("wrap_pc_top", out_pc, 32'hFFC);
    check_eq("wrap_instr_top", out_instr, 32'h1000_03FF);
    check_eq("wrap_addr_zero", 32'(imem_addr), 32'd0);
    @(negedge clk);
    check_eq("wrap_pc_next", out_pc, 32'h1000);
    check_eq("wrap_instr_next", out_instr, 32'h1000_0000);
    check_eq("wrap_addr_one", 32'(imem_addr), 32'd1);

    // Redirect held for three cycles
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    check_eq("held_valid1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("held_valid2", 32'(out_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    check_eq("held_valid3", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("held_out_valid", 32'(out_valid), 32'd1);
    check_eq("held_out_pc", out_pc, 32'h200);
    check_eq("held_out_instr", out_instr, 32'h1000_0080);

    // Redirect on a full buffer with decode stalled
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("full_head_pc", out_pc, 32'h204);
    repeat (2) @(negedge clk);
    check_eq("full_count", 32'(u_dut.u_fifo.count_o), 32'd2);
    check_eq("full_head_hold", out_pc, 32'h204);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_count", 32'(u_dut.u_fifo.count_o), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    check_eq("flush_out_valid", 32'(out_valid), 32'd1);
    check_eq("flush_out_pc", out_pc, 32'h40);
    check_eq("flush_out_instr", out_instr, 32'h1000_0010);
    @(negedge clk);
    check_eq("flush_next_pc", out_pc, 32'h44);

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst2_valid", 32'(out_valid), 32'd0);
    check_eq("rst2_instr", out_instr, 32'h0);
    check_eq("rst2_pc", out_pc, 32'h0);
    check_eq("rst2_addr", 32'(imem_addr), 32'd0);
    check_eq("rst2_count", 32'(u_dut.u_fifo.count_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("restart_gap_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("restart_valid", 32'(out_valid), 32'd1);
    check_eq("restart_pc", out_pc, 32'h0);
    check_eq("restart_instr", out_instr, 32'h1000_0000);
    @(negedge clk);
    check_eq("restart_next_pc", out_pc, 32'h4);
    check_eq("restart_next_instr", out_instr, 32'h1000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
